// File: rtl/plp_pkg.sv
// plp_pkg -- constants and helpers shared by the interrupt controller.
//
// Holds the register word offsets (decoded from daddr[4:2]), the bit
// positions of the drw bus command, the default register window base and
// a lowest-set-bit helper used by the optional priority VECTOR register.
package plp_pkg;

    // Default byte base address of the interrupt controller window.
    localparam logic [31:0] INTC_BASE_DEFAULT = 32'hf070_0000;

    // Maximum number of interrupt sources supported by the register layout.
    localparam int INTC_MAX_SRC = 16;

    // Word offsets as seen on daddr[4:2].
    localparam logic [2:0] REG_MASK    = 3'd0;  // 0x00
    localparam logic [2:0] REG_STATUS  = 3'd1;  // 0x04
    localparam logic [2:0] REG_PENDING = 3'd2;  // 0x08
    localparam logic [2:0] REG_CTRL    = 3'd3;  // 0x0C
    localparam logic [2:0] REG_VECTOR  = 3'd4;  // 0x10

    // drw command bit positions.
    localparam int DRW_WR_BIT = 0;
    localparam int DRW_RD_BIT = 1;

    // Returns {valid, index} of the lowest-numbered set bit of vec.
    // valid is 0 (and index 0) when no bit is set.
    function automatic logic [4:0] lowest_pending(input logic [INTC_MAX_SRC-1:0] vec);
        logic [4:0] result;
        result = 5'd0;
        // Scan from the top down so the lowest set bit is the last to write.
        for (int i = INTC_MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                result = {1'b1, 4'(i)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/intc_edge_sync.sv
// intc_edge_sync -- two-flop synchronizer followed by a rising-edge detector
// for one asynchronous interrupt request line.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset, clears all three flops
//   async_in  in   raw asynchronous request line
//   rise      out  one-cycle pulse (combinational from flops) when the
//                  synchronized line goes 0 -> 1; the owner of the status
//                  bit samples it on the same edge that updates prev_q
module intc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/mod_interrupt_ctrl.sv
// mod_interrupt_ctrl -- memory-mapped interrupt controller.
//
// Register window (word offset from daddr[4:2]):
//   0x00 MASK     RW   per-source enable
//   0x04 STATUS   R/W1C latched rising edges of the synchronized sources
//   0x08 PENDING  R    STATUS & MASK
//   0x0C CTRL     RW   bit0 = GIE (global interrupt enable)
//   0x10 VECTOR   R    {valid, 27'b0, index of lowest PENDING bit} when
//                      built with INTC_PRIORITY_EN, otherwise reads 0
//   others             read 0, writes ignored
//
// Configuration macro: INTC_PRIORITY_EN enables the registered VECTOR
// register; without it no priority logic is built.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   de       in   data bus select
//   daddr    in   byte address (only [4:2] decoded; the arbiter qualifies BASE)
//   drw      in   bus command, bit0 = write, bit1 = read
//   din      in   write data
//   dout     out  combinational read data, 0 when not reading
//   irq_src  in   raw asynchronous interrupt lines
//   int_ack  in   interrupt entry pulse, clears GIE
//   int_req  out  registered interrupt request to the CPU ("int" itself is a
//                 SystemVerilog keyword, so the port carries this name)
module mod_interrupt_ctrl
    import plp_pkg::*;
#(
    parameter int          NSRC = 8,
    parameter logic [31:0] BASE = INTC_BASE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            de,
    input  logic [31:0]     daddr,
    input  logic [1:0]      drw,
    input  logic [31:0]     din,
    output logic [31:0]     dout,
    input  logic [NSRC-1:0] irq_src,
    input  logic            int_ack,
    output logic            int_req
);

    logic [NSRC-1:0] mask_q,   mask_d;
    logic [NSRC-1:0] status_q, status_d;
    logic            gie_q,    gie_d;
    logic            int_q,    int_d;

    logic [NSRC-1:0]         rise_vec;
    logic [INTC_MAX_SRC-1:0] pending_ext;
    logic [31:0]             vector_rd;
    logic [31:0]             rdata;
    logic [2:0]              sel;
    logic                    wr_en;
    logic                    rd_en;

    // The window base is matched by the arbiter through de, so only the
    // word-offset bits of the address matter here.
    logic unused_bits;
    assign unused_bits = ^{BASE, daddr[31:5], daddr[1:0], din[31:NSRC]};

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_sync
            intc_edge_sync u_edge_sync (
                .clk      (clk),
                .rst      (rst),
                .async_in (irq_src[gi]),
                .rise     (rise_vec[gi])
            );
        end
    endgenerate

    assign sel   = daddr[4:2];
    assign wr_en = de & drw[DRW_WR_BIT];
    assign rd_en = de & drw[DRW_RD_BIT];

    always_comb begin
        pending_ext           = '0;
        pending_ext[NSRC-1:0] = status_q & mask_q;
    end

    // Register next-state logic.
    always_comb begin
        mask_d   = mask_q;
        status_d = status_q;
        gie_d    = gie_q;

        if (wr_en && sel == REG_MASK) begin
            mask_d = din[NSRC-1:0];
        end

        // W1C clear first, then OR in new edges so a coincident edge wins.
        if (wr_en && sel == REG_STATUS) begin
            status_d = status_q & ~din[NSRC-1:0];
        end
        status_d = status_d | rise_vec;

        // A CTRL write takes precedence over the acknowledge clearing GIE.
        if (wr_en && sel == REG_CTRL) begin
            gie_d = din[0];
        end else if (int_ack) begin
            gie_d = 1'b0;
        end

        int_d = gie_q & (|(status_q & mask_q));
    end

`ifdef INTC_PRIORITY_EN
    logic [31:0] vector_q, vector_d;
    logic [4:0]  lowest;

    always_comb begin
        lowest   = lowest_pending(pending_ext);
        vector_d = {lowest[4], 27'd0, lowest[3:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vector_q <= '0;
        end else begin
            vector_q <= vector_d;
        end
    end

    assign vector_rd = vector_q;
`else
    assign vector_rd = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q   <= '0;
            status_q <= '0;
            gie_q    <= 1'b0;
            int_q    <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            status_q <= status_d;
            gie_q    <= gie_d;
            int_q    <= int_d;
        end
    end

    // Read mux: shows current (pre-write) register contents.
    always_comb begin
        rdata = '0;
        case (sel)
            REG_MASK:    rdata[NSRC-1:0] = mask_q;
            REG_STATUS:  rdata[NSRC-1:0] = status_q;
            REG_PENDING: rdata[INTC_MAX_SRC-1:0] = pending_ext;
            REG_CTRL:    rdata[0] = gie_q;
            REG_VECTOR:  rdata = vector_rd;
            default:     rdata = '0;
        endcase
    end

    assign dout    = rd_en ? rdata : 32'd0;
    assign int_req = int_q;

endmodule

// File: tb/tb_mod_interrupt_ctrl.sv
// Self-checking bench for mod_interrupt_ctrl: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_mod_interrupt_ctrl;

    localparam int          NSRC = 8;
    localparam logic [31:0] BASE = 32'hf070_0000;
    localparam logic [31:0] O_MASK    = 32'h00;
    localparam logic [31:0] O_STATUS  = 32'h04;
    localparam logic [31:0] O_PENDING = 32'h08;
    localparam logic [31:0] O_CTRL    = 32'h0C;
    localparam logic [31:0] O_VECTOR  = 32'h10;

    logic            clk;
    logic            rst;
    logic            de;
    logic [31:0]     daddr;
    logic [1:0]      drw;
    logic [31:0]     din;
    logic [31:0]     dout;
    logic [NSRC-1:0] irq_src;
    logic            int_ack;
    logic            int_req;

    int total = 0;
    int bad   = 0;

    mod_interrupt_ctrl #(.NSRC(NSRC), .BASE(BASE)) dut (
        .clk     (clk),
        .rst     (rst),
        .de      (de),
        .daddr   (daddr),
        .drw     (drw),
        .din     (din),
        .dout    (dout),
        .irq_src (irq_src),
        .int_ack (int_ack),
        .int_req (int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
        daddr = BASE + off;
        din   = data;
        drw   = 2'b01;
        de    = 1'b1;
        tick();
        de    = 1'b0;
        drw   = 2'b00;
        $display("  wr  off=%02h data=%08h", off, data);
    endtask

    task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
        daddr = BASE + off;
        drw   = 2'b10;
        de    = 1'b1;
        #1;
        data  = dout;
        de    = 1'b0;
        drw   = 2'b00;
        #1;
        $display("  rd  off=%02h data=%08h", off, data);
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        $display("test_reset");
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (int_req !== 1'b0) begin bad++; $display("FAIL reset_int got=%0b exp=0", int_req); end
        total++;
        if (dout !== 32'd0) begin bad++; $display("FAIL reset_dout_idle got=%08h exp=0", dout); end
        bus_read(O_STATUS, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL reset_status got=%08h exp=0", rd); end
        bus_read(O_MASK, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL reset_mask got=%08h exp=0", rd); end
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (4) tick();
        bus_read(O_CTRL, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL reset_ctrl got=%08h exp=0", rd); end
    endtask

    task automatic test_irq_latency;
        logic [31:0] rd;
        $display("test_irq_latency");
        bus_write(O_MASK, 32'h01);
        bus_write(O_CTRL, 32'h01);
        irq_src[0] = 1'b1;
        tick();
        tick();
        bus_read(O_STATUS, rd);
        total++;
        if (rd !== 32'h00) begin bad++; $display("FAIL latency_status_edge2 got=%08h exp=0", rd); end
        tick();
        bus_read(O_STATUS, rd);
        total++;
        if (rd !== 32'h01) begin bad++; $display("FAIL latency_status_edge3 got=%08h exp=1", rd); end
        total++;
        if (int_req !== 1'b0) begin bad++; $display("FAIL latency_int_edge3 got=%0b exp=0", int_req); end
        tick();
        total++;
        if (int_req !== 1'b1) begin bad++; $display("FAIL latency_int_edge4 got=%0b exp=1", int_req); end
        tick();
        irq_src[0] = 1'b0;
    endtask

    task automatic test_int_ack;
        logic [31:0] rd;
        $display("test_int_ack");
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        bus_read(O_CTRL, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL ack_gie got=%08h exp=0", rd); end
        tick();
        total++;
        if (int_req !== 1'b0) begin bad++; $display("FAIL ack_int got=%0b exp=0", int_req); end
        bus_read(O_STATUS, rd);
        total++;
        if (rd !== 32'h01) begin bad++; $display("FAIL ack_status got=%08h exp=1", rd); end
    endtask

    task automatic test_w1c_collision;
        logic [31:0] rd;
        $display("test_w1c_collision");
        repeat (4) tick();
        irq_src[0] = 1'b1;
        tick();
        tick();
        bus_write(O_STATUS, 32'h01);   // third edge: detect and clear together
        bus_read(O_STATUS, rd);
        total++;
        if (rd !== 32'h01) begin bad++; $display("FAIL w1c_collision got=%08h exp=1", rd); end
        irq_src[0] = 1'b0;
        repeat (3) tick();
        bus_write(O_STATUS, 32'h01);
        bus_read(O_STATUS, rd);
        total++;
        if (rd !== 32'h00) begin bad++; $display("FAIL w1c_clear got=%08h exp=0", rd); end
    endtask

    task automatic test_masked;
        logic [31:0] rd;
        $display("test_masked");
        bus_write(O_MASK, 32'h00);
        bus_write(O_CTRL, 32'h01);
        irq_src[3] = 1'b1;
        repeat (4) tick();
        irq_src[3] = 1'b0;
        bus_read(O_STATUS, rd);
        total++;
        if (rd !== 32'h08) begin bad++; $display("FAIL masked_status got=%08h exp=8", rd); end
        total++;
        if (int_req !== 1'b0) begin bad++; $display("FAIL masked_int got=%0b exp=0", int_req); end
        bus_write(O_MASK, 32'h08);
        total++;
        if (int_req !== 1'b0) begin bad++; $display("FAIL unmask_int_early got=%0b exp=0", int_req); end
        tick();
        total++;
        if (int_req !== 1'b1) begin bad++; $display("FAIL unmask_int got=%0b exp=1", int_req); end
        bus_read(O_PENDING, rd);
        total++;
        if (rd !== 32'h08) begin bad++; $display("FAIL unmask_pending got=%08h exp=8", rd); end
    endtask

    task automatic test_rw_same_cycle;
        logic [31:0] rd;
        $display("test_rw_same_cycle");
        daddr = BASE + O_MASK;
        din   = 32'h55;
        drw   = 2'b11;
        de    = 1'b1;
        #1;
        rd = dout;
        $display("  rw  off=00 data=%08h read=%08h", din, rd);
        total++;
        if (rd !== 32'h08) begin bad++; $display("FAIL rw_preread got=%08h exp=8", rd); end
        tick();
        de  = 1'b0;
        drw = 2'b00;
        bus_read(O_MASK, rd);
        total++;
        if (rd !== 32'h55) begin bad++; $display("FAIL rw_written got=%08h exp=55", rd); end
        bus_write(32'h14, 32'hffff_ffff);
        bus_read(32'h14, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%08h exp=0", rd); end
    endtask

    task automatic test_vector;
        logic [31:0] rd;
        logic [31:0] exp_vec;
        $display("test_vector");
`ifdef INTC_PRIORITY_EN
        exp_vec = 32'h8000_0002;
`else
        exp_vec = 32'h0;
`endif
        bus_write(O_STATUS, 32'hff);
        bus_write(O_MASK, 32'hff);
        irq_src = 8'h0c;
        repeat (4) tick();
        irq_src = 8'h00;
        bus_read(O_PENDING, rd);
        total++;
        if (rd !== 32'h0c) begin bad++; $display("FAIL vector_pending got=%08h exp=0c", rd); end
        tick();
        bus_read(O_VECTOR, rd);
        total++;
        if (rd !== exp_vec) begin bad++; $display("FAIL vector_read got=%08h exp=%08h", rd, exp_vec); end
        repeat (4) tick();
    endtask

    task automatic test_async_reset;
        logic [31:0] rd;
        $display("test_async_reset");
        bus_write(O_MASK, 32'hff);
        bus_write(O_CTRL, 32'h01);
        irq_src = 8'hff;
        repeat (4) tick();
        irq_src = 8'h00;
        bus_read(O_STATUS, rd);
        total++;
        if (rd !== 32'hff) begin bad++; $display("FAIL pre_reset_status got=%08h exp=ff", rd); end
        tick();
        total++;
        if (int_req !== 1'b1) begin bad++; $display("FAIL pre_reset_int got=%0b exp=1", int_req); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (int_req !== 1'b0) begin bad++; $display("FAIL async_reset_int got=%0b exp=0", int_req); end
        bus_read(O_STATUS, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL async_reset_status got=%08h exp=0", rd); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick();
        bus_read(O_STATUS, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL post_reset_status got=%08h exp=0", rd); end
        bus_read(O_MASK, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL post_reset_mask got=%08h exp=0", rd); end
        total++;
        if (int_req !== 1'b0) begin bad++; $display("FAIL post_reset_int got=%0b exp=0", int_req); end
    endtask

    // Model: STATUS latches a source bit three edges after the bench first
    // drives it high (two synchronizer stages, then edge detection). int is
    // the previous cycle's GIE & |PENDING.
    task automatic test_random;
        logic [NSRC-1:0] hist [4];
        logic [NSRC-1:0] m_status, m_mask, rise, w1c;
        logic            m_gie, m_int, new_int;
        logic [31:0]     rd, wdata;
        int              op;
        $display("test_random");
        m_status = '0;
        m_mask   = '0;
        m_gie    = 1'b0;
        m_int    = 1'b0;
        for (int k = 0; k < 4; k++) hist[k] = '0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            irq_src = irq_src ^ NSRC'($urandom & $urandom & $urandom);
            op    = $urandom_range(0, 5);
            wdata = $urandom;
            de    = 1'b0;
            drw   = 2'b00;
            int_ack = 1'b0;
            w1c   = '0;
            case (op)
                0: begin daddr = BASE + O_MASK;   din = wdata; drw = 2'b01; de = 1'b1; end
                1: begin daddr = BASE + O_STATUS; din = wdata; drw = 2'b01; de = 1'b1; end
                2: begin daddr = BASE + O_CTRL;   din = wdata; drw = 2'b01; de = 1'b1; end
                3: begin int_ack = 1'b1; end
                4: begin daddr = BASE + O_CTRL;   din = wdata; drw = 2'b01; de = 1'b1; int_ack = 1'b1; end
                default: ;
            endcase
            @(posedge clk);
            #1;
            // Model the edge just taken.
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq_src;
            rise    = hist[2] & ~hist[3];
            new_int = m_gie & (|(m_status & m_mask));
            if (op == 1) w1c = wdata[NSRC-1:0];
            m_status = (m_status & ~w1c) | rise;
            if (op == 0) m_mask = wdata[NSRC-1:0];
            if (op == 2 || op == 4) m_gie = wdata[0];
            else if (op == 3) m_gie = 1'b0;
            m_int = new_int;
            de = 1'b0;
            drw = 2'b00;
            int_ack = 1'b0;
            $display("  cyc=%0d op=%0d irq=%02h data=%08h status=%02h mask=%02h gie=%0b int=%0b",
                     cyc, op, irq_src, wdata, m_status, m_mask, m_gie, m_int);
            total++;
            if (int_req !== m_int) begin bad++; $display("FAIL rand_int cyc=%0d got=%0b exp=%0b", cyc, int_req, m_int); end
            bus_read(O_STATUS, rd);
            total++;
            if (rd !== 32'(m_status)) begin bad++; $display("FAIL rand_status cyc=%0d got=%08h exp=%08h", cyc, rd, m_status); end
            bus_read(O_PENDING, rd);
            total++;
            if (rd !== 32'(m_status & m_mask)) begin bad++; $display("FAIL rand_pending cyc=%0d got=%08h exp=%08h", cyc, rd, m_status & m_mask); end
            bus_read(O_CTRL, rd);
            total++;
            if (rd !== 32'(m_gie)) begin bad++; $display("FAIL rand_ctrl cyc=%0d got=%08h exp=%08h", cyc, rd, m_gie); end
        end
        irq_src = '0;
    endtask

    initial begin
        rst     = 1'b1;
        de      = 1'b0;
        daddr   = 32'd0;
        drw     = 2'b00;
        din     = 32'd0;
        irq_src = '0;
        int_ack = 1'b0;
        test_reset();
        test_irq_latency();
        test_int_ack();
        test_w1c_collision();
        test_masked();
        test_rw_same_cycle();
        test_vector();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
